waveform_buffer_reader: RTL

// - Drains stored waveforms from the waveform buffer storage block: pops one header, reads that waveform's samples

---
 rtl/wvb_reader_pkg.sv | 24 ++
 rtl/wvb_reader_out_fifo.sv | 62 ++++++
 rtl/waveform_buffer_reader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/wvb_reader_pkg.sv
// Shared types and constants for the waveform buffer reader.
package wvb_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_LATCH,
    S_HDR_OUT,
    S_SAMPLES,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int unsigned START_LSB = 0;
  localparam int unsigned STOP_LSB  = 15;
  localparam int unsigned HDR_WORDS = 3;
  localparam int unsigned OUT_WIDTH = 32;

  typedef struct packed {
    logic                 last;
    logic [OUT_WIDTH-1:0] data;
  } out_word_t;

endpackage

// File: rtl/wvb_reader_out_fifo.sv
// Synchronous FIFO with a registered output stage; count includes the output register.
module wvb_reader_out_fifo #(
  parameter int unsigned P_WIDTH = 33,
  parameter int unsigned P_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [P_WIDTH-1:0]         push_data,
  input  logic                       ready,
  output logic [P_WIDTH-1:0]         out_data,
  output logic                       out_valid,
  output logic [$clog2(P_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(P_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [P_WIDTH-1:0] mem [P_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      mem_count;
  logic               load_c, mem_rd_c, mem_wr_c;

  // Output register refills from memory first; bypasses a push only when memory is empty.
  always_comb begin
    load_c   = !out_valid || ready;
    mem_rd_c = load_c && (mem_count != '0);
    mem_wr_c = push && !(load_c && (mem_count == '0));
  end

  always_ff @(posedge clk) begin
    if (mem_wr_c) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      count     <= '0;
    end else begin
      if (load_c) begin
        if (mem_rd_c) begin
          out_data  <= mem[rd_ptr];
          out_valid <= 1'b1;
        end else if (push) begin
          out_data  <= push_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (mem_rd_c) rd_ptr <= rd_ptr + AW'(1);
      if (mem_wr_c) wr_ptr <= wr_ptr + AW'(1);
      mem_count <= mem_count + CW'(mem_wr_c) - CW'(mem_rd_c);
      count     <= count + CW'(push) - CW'(out_valid && ready);
    end
  end

endmodule

// File: rtl/waveform_buffer_reader.sv
// Drains one stored waveform per header: header words then samples on a valid/ready stream.
// Optional EOE marker checking is built when WVB_READER_EOE_CHECK_EN is defined.
module waveform_buffer_reader
  import wvb_reader_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH     = 28,
  parameter int unsigned P_ADR_WIDTH      = 15,
  parameter int unsigned P_HDR_WIDTH      = 87,
  parameter int unsigned P_RD_LATENCY     = 1,
  parameter int unsigned P_OUT_FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  input  logic                    hdr_empty,
  output logic                    hdr_rdreq,
  input  logic [P_DATA_WIDTH-1:0] wvb_data,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  output logic [OUT_WIDTH-1:0]    dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_last,
  output logic [P_ADR_WIDTH-1:0]  rd_free_addr,
  output logic                    busy,
  output logic                    eoe_err
);

  localparam int unsigned CW = $clog2(P_OUT_FIFO_DEPTH) + 1;

  state_t                  state;
  logic [P_HDR_WIDTH-1:0]  hdr_q;
  logic [P_ADR_WIDTH-1:0]  cur_addr, stop_addr;
  logic [1:0]              word_idx;
  logic [P_RD_LATENCY:0]   rd_pipe, last_pipe;
  logic [CW-1:0]           fifo_count;
  out_word_t               push_word_c, fifo_out;
  logic                    push_c, space_c, credit_ok_c, issue_c, issue_last_c;
  int unsigned             inflight_c;

  // Reads still on their way to the FIFO are charged against its free space.
  always_comb begin
    inflight_c = 0;
    for (int unsigned i = 0; i <= P_RD_LATENCY; i++) inflight_c = inflight_c + 32'(rd_pipe[i]);
    credit_ok_c  = (32'(fifo_count) + inflight_c) < P_OUT_FIFO_DEPTH;
    space_c      = fifo_count < CW'(P_OUT_FIFO_DEPTH);
    issue_c      = (state == S_SAMPLES) && credit_ok_c;
    issue_last_c = issue_c && (cur_addr == stop_addr);
  end

  always_comb begin
    push_c      = 1'b0;
    push_word_c = '0;
    if (rd_pipe[P_RD_LATENCY]) begin
      push_c           = 1'b1;
      push_word_c.last = last_pipe[P_RD_LATENCY];
      push_word_c.data = OUT_WIDTH'(wvb_data);
    end else if ((state == S_HDR_OUT) && space_c) begin
      push_c = 1'b1;
      case (word_idx)
        2'd0:    push_word_c.data = hdr_q[31:0];
        2'd1:    push_word_c.data = hdr_q[63:32];
        default: push_word_c.data = OUT_WIDTH'(hdr_q[P_HDR_WIDTH-1:64]);
      endcase
    end
  end

  // Bit 0 of each pipe stage lines up with wvb_rd_addr; the top bit with returning wvb_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pipe   <= '0;
      last_pipe <= '0;
    end else begin
      rd_pipe   <= {rd_pipe[P_RD_LATENCY-1:0], issue_c};
      last_pipe <= {last_pipe[P_RD_LATENCY-1:0], issue_last_c};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      hdr_rdreq    <= 1'b0;
      busy         <= 1'b0;
      hdr_q        <= '0;
      cur_addr     <= '0;
      stop_addr    <= '0;
      word_idx     <= '0;
      wvb_rd_addr  <= '0;
      rd_free_addr <= '0;
    end else begin
      case (state)
        S_IDLE: if (!hdr_empty) begin
          state     <= S_POP;
          hdr_rdreq <= 1'b1;
          busy      <= 1'b1;
        end
        S_POP: begin
          hdr_rdreq <= 1'b0;
          state     <= S_LATCH;
        end
        S_LATCH: begin
          hdr_q     <= hdr_data;
          cur_addr  <= hdr_data[START_LSB +: P_ADR_WIDTH];
          stop_addr <= hdr_data[STOP_LSB +: P_ADR_WIDTH];
          word_idx  <= '0;
          state     <= S_HDR_OUT;
        end
        S_HDR_OUT: if (space_c) begin
          word_idx <= word_idx + 2'd1;
          if (word_idx == 2'(HDR_WORDS - 1)) state <= S_SAMPLES;
        end
        S_SAMPLES: if (issue_c) begin
          wvb_rd_addr <= cur_addr;
          cur_addr    <= cur_addr + P_ADR_WIDTH'(1);
          if (issue_last_c) state <= S_DRAIN;
        end
        S_DRAIN: if ((fifo_count == '0) && (rd_pipe == '0)) state <= S_DONE;
        S_DONE: begin
          rd_free_addr <= stop_addr + P_ADR_WIDTH'(1);
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  wvb_reader_out_fifo #(
    .P_WIDTH ($bits(out_word_t)),
    .P_DEPTH (P_OUT_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (push_word_c),
    .ready     (dout_ready),
    .out_data  (fifo_out),
    .out_valid (dout_valid),
    .count     (fifo_count)
  );

  assign dout      = fifo_out.data;
  assign dout_last = fifo_out.last;

`ifdef WVB_READER_EOE_CHECK_EN
  logic eoe_q;
  // EOE must be set exactly on the final sample of each waveform.
  always_ff @(posedge clk) begin
    if (rst) eoe_q <= 1'b0;
    else if (rd_pipe[P_RD_LATENCY] && (wvb_data[0] != last_pipe[P_RD_LATENCY])) eoe_q <= 1'b1;
  end
  assign eoe_err = eoe_q;
`else
  assign eoe_err = 1'b0;
`endif

endmodule
